// File: rtl/rc_servo_pkg.sv
// Shared definitions for the RC servo sigma-delta front end.
// Holds parameter defaults, the IIR smoothing shift and the window state type.
// No ports; imported by rc_servo_sync users and rc_servo_sd_front.
package rc_servo_pkg;

   localparam int WIN_BITS_DEF    = 8;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int SD_IIR_SHIFT    = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sd_state_t;

endpackage

// File: rtl/rc_servo_sync.sv
// N-stage single-bit synchroniser for asynchronous pad inputs.
// Latency: N clocks from d to q. No backpressure (free-running).
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module rc_servo_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[N-2:0], d};
      end
   end

   assign q = sr[N-1];

endmodule

// File: rtl/rc_servo_sd_front.sv
// First-order sigma-delta ADC front end for one joystick axis.
// Latency: sample updates on the edge ending the 2**WIN_BITS-cycle window; fb_o lags the pin by SYNC_STAGES clocks.
// Backpressure: valid/ready; an unaccepted sample is overwritten by the next capture and overrun_o is set (sticky).
// Ports: clk, rst_n, en_i, comp_async_i, fb_o, sample_o/sample_valid_o/sample_ready_i, overrun_o, ovr_clr_i.
// Optional macro RC_SERVO_SD_IIR_EN: smooth each captured count with a 1/4-gain first-order IIR.
module rc_servo_sd_front
   import rc_servo_pkg::*;
#(
   parameter int WIN_BITS    = WIN_BITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                comp_async_i,
   output logic                fb_o,
   output logic [WIN_BITS-1:0] sample_o,
   output logic                sample_valid_o,
   input  logic                sample_ready_i,
   output logic                overrun_o,
   input  logic                ovr_clr_i
);

   localparam logic [WIN_BITS-1:0] WCNT_LAST = '1;

   logic                comp_s;
   sd_state_t           state;
   logic [WIN_BITS-1:0] wcnt;
   logic [WIN_BITS:0]   acc;
   logic [WIN_BITS:0]   total;
   logic [WIN_BITS-1:0] raw_sat;
   logic [WIN_BITS-1:0] cap_val;
   logic                cap;
   logic                xfer;

   rc_servo_sync #(.N(SYNC_STAGES)) u_comp_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (comp_async_i),
      .q     (comp_s)
   );

   // The feedback bit closes the modulator loop and runs regardless of en_i.
   assign fb_o = comp_s;

   // Count including the current cycle's comparator bit; a window of all
   // ones reaches 2**WIN_BITS, one past the sample range, so clamp it.
   assign total   = acc + {{WIN_BITS{1'b0}}, comp_s};
   assign raw_sat = total[WIN_BITS] ? '1 : total[WIN_BITS-1:0];
   assign cap     = en_i && (state == RUN) && (wcnt == WCNT_LAST);
   assign xfer    = sample_valid_o && sample_ready_i;

`ifdef RC_SERVO_SD_IIR_EN
   logic signed [WIN_BITS:0] y;
   logic signed [WIN_BITS:0] diff;
   logic signed [WIN_BITS:0] y_new;

   assign diff    = $signed({1'b0, raw_sat}) - y;
   assign y_new   = y + (diff >>> SD_IIR_SHIFT);
   // y tracks a value in [0, 2**WIN_BITS-1], so the sign bit is always 0 here.
   assign cap_val = y_new[WIN_BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y <= '0;
      end else if (cap) begin
         y <= y_new;
      end
   end
`else
   assign cap_val = raw_sat;
`endif

   // Window FSM. The first enabled cycle already counts, so entry from IDLE
   // performs the first accumulation; dropping en_i discards the partial window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wcnt  <= '0;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en_i) begin
                  state <= RUN;
                  acc   <= total;
                  wcnt  <= wcnt + 1'b1;
               end else begin
                  acc  <= '0;
                  wcnt <= '0;
               end
            end
            RUN: begin
               if (!en_i) begin
                  state <= IDLE;
                  acc   <= '0;
                  wcnt  <= '0;
               end else if (wcnt == WCNT_LAST) begin
                  acc  <= '0;
                  wcnt <= '0;
               end else begin
                  acc  <= total;
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               acc   <= '0;
               wcnt  <= '0;
            end
         endcase
      end
   end

   // Output register and handshake. A capture always wins over a transfer;
   // overrun only when the old sample is lost (valid, not being taken).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         if (cap) begin
            sample_o       <= cap_val;
            sample_valid_o <= 1'b1;
         end else if (xfer) begin
            sample_valid_o <= 1'b0;
         end
         if (cap && sample_valid_o && !sample_ready_i) begin
            overrun_o <= 1'b1;
         end else if (ovr_clr_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

endmodule
